// File: rtl/mdu_seq.sv
// Iterative M-extension sequencer: 64-step shift-add multiply / restoring divide
// on operand magnitudes, one-cycle sign fix-up, result held until consumed.
module mdu_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      rd_i,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_o,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN-1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        op_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic              neg_a;
  logic              neg_b;

  logic            op_onehot;
  logic            is_mul_op;
  logic            is_div_op;
  logic            signed1;
  logic            signed2;
  logic            s1_neg;
  logic            s2_neg;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            fast;
  logic [XLEN-1:0] fast_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] div_next;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   acc_lo;
  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_res;

  assign in_ready = (state == IDLE) && !flush;
  assign busy     = (state != IDLE);

  // Operand decode: signedness per op, then magnitudes used by both datapaths.
  always_comb begin
    op_onehot = (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
    is_mul_op = |op[3:0];
    is_div_op = |op[7:4];
    signed1   = op[0] | op[1] | op[2] | op[4] | op[6];
    signed2   = op[0] | op[1] | op[4] | op[6];
    s1_neg    = signed1 & src1[XLEN-1];
    s2_neg    = signed2 & src2[XLEN-1];
    mag1      = s1_neg ? -src1 : src1;
    mag2      = s2_neg ? -src2 : src2;
  end

  // Cases whose answer is known without iterating.
  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    if (!op_onehot) begin
      fast     = 1'b1;
      fast_res = '0;
    end else if (is_div_op && (src2 == '0)) begin
      fast     = 1'b1;
      fast_res = (op[4] | op[5]) ? '1 : src1;
    end else if ((op[4] | op[6]) && (src1 == MIN_NEG) && (src2 == '1)) begin
      fast     = 1'b1;
      fast_res = op[4] ? MIN_NEG : '0;
    end
  end

  // One iteration of each datapath; acc holds {partial, multiplier/dividend}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    div_ge   = rem_sh >= {1'b0, opnd};
    div_sub  = rem_sh[XLEN-1:0] - opnd;
    div_next = {div_ge ? div_sub : rem_sh[XLEN-1:0], acc[XLEN-2:0], div_ge};
  end

  always_comb begin
    acc_lo  = acc[XLEN-1:0];
    acc_hi  = acc[2*XLEN-1:XLEN];
    prod    = neg_a ? -acc : acc;
    quo     = neg_a ? -acc_lo : acc_lo;
    rem     = neg_b ? -acc_hi : acc_hi;
    fix_res = '0;
    if (op_q[0])
      fix_res = prod[XLEN-1:0];
    else if (|op_q[3:1])
      fix_res = prod[2*XLEN-1:XLEN];
    else if (|op_q[5:4])
      fix_res = quo;
    else if (|op_q[7:6])
      fix_res = rem;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      acc       <= '0;
      opnd      <= '0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      rd_o      <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q  <= op;
            rd_o  <= rd_i;
            neg_a <= s1_neg ^ s2_neg;
            neg_b <= s1_neg;
            cnt   <= '0;
            if (fast) begin
              result    <= fast_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (is_mul_op) begin
              acc   <= {{XLEN{1'b0}}, mag2};
              opnd  <= mag1;
              state <= MUL;
            end else begin
              acc   <= {{XLEN{1'b0}}, mag1};
              opnd  <= mag2;
              state <= DIV;
            end
          end
        end
        MUL: begin
          acc <= mul_next;
          if (cnt == LAST_STEP) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          acc <= div_next;
          if (cnt == LAST_STEP) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          result    <= fix_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: vector table plus random ops checked against an arithmetic
// model through a scoreboard, then flush / reset / back-pressure sequences.
module tb_mdu_seq;

  localparam logic [7:0] OP_MUL    = 8'h01;
  localparam logic [7:0] OP_MULH   = 8'h02;
  localparam logic [7:0] OP_MULHSU = 8'h04;
  localparam logic [7:0] OP_MULHU  = 8'h08;
  localparam logic [7:0] OP_DIV    = 8'h10;
  localparam logic [7:0] OP_DIVU   = 8'h20;
  localparam logic [7:0] OP_REM    = 8'h40;
  localparam logic [7:0] OP_REMU   = 8'h80;
  localparam logic [63:0] MINV     = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [7:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] val;
    logic [4:0]  rd;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  op;
  logic [63:0] src1;
  logic [63:0] src2;
  logic [4:0]  rd_i;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [4:0]  rd_o;
  logic        busy;

  int   checks;
  int   failures;
  exp_t scoreboard[$];
  vec_t vecs[$];

  mdu_seq #(.XLEN(64), .CNT_W(7)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .rd_i      (rd_i),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .rd_o      (rd_o),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [7:0] m_op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [127:0]       ea;
    logic [127:0]       eb;
    logic [127:0]       p;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sr;
    ea = {{64{a[63]}}, a};
    eb = {{64{b[63]}}, b};
    sa = a;
    sb = b;
    model = '0;
    case (m_op)
      OP_MUL:    model = a * b;
      OP_MULH:   begin p = ea * eb;           model = p[127:64]; end
      OP_MULHSU: begin p = ea * {64'd0, b};   model = p[127:64]; end
      OP_MULHU:  begin p = {64'd0, a} * {64'd0, b}; model = p[127:64]; end
      OP_DIV: begin
        if (b == 64'd0) model = ONES;
        else if (a == MINV && b == ONES) model = MINV;
        else begin sr = sa / sb; model = sr; end
      end
      OP_DIVU: begin
        if (b == 64'd0) model = ONES;
        else model = a / b;
      end
      OP_REM: begin
        if (b == 64'd0) model = a;
        else if (a == MINV && b == ONES) model = 64'd0;
        else begin sr = sa % sb; model = sr; end
      end
      OP_REMU: begin
        if (b == 64'd0) model = a;
        else model = a % b;
      end
      default: model = '0;
    endcase
  endfunction

  // Present one op at a negedge; it is accepted at the following posedge.
  task automatic applyStimulus(input logic [7:0] v_op, input logic [63:0] a,
                               input logic [63:0] b, input logic [4:0] rd,
                               input logic [63:0] exp_val, input bit expect_out);
    exp_t e;
    @(negedge clock);
    op       = v_op;
    src1     = a;
    src2     = b;
    rd_i     = rd;
    in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1);
    if (expect_out) begin
      e.val = exp_val;
      e.rd  = rd;
      scoreboard.push_back(e);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    src1     = {$urandom, $urandom};
    src2     = {$urandom, $urandom};
    rd_i     = 5'($urandom);
  endtask

  // Wait for the result, check latency/value/tag, optionally stall the consumer.
  task automatic checkOutput(input int exp_lat, input int hold);
    int   cyc;
    bit   seen;
    bit   ready_high;
    bit   stable;
    exp_t e;
    out_ready  = (hold == 0);
    seen       = 1'b0;
    ready_high = 1'b0;
    cyc        = 0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clock);
      if (in_ready) ready_high = 1'b1;
      if (out_valid) begin
        seen = 1'b1;
        cyc  = c;
        break;
      end
    end
    check("out_valid_seen", seen, 1);
    if (!seen) begin
      if (scoreboard.size() > 0) void'(scoreboard.pop_front());
      out_ready = 1'b0;
      return;
    end
    check("latency", cyc, exp_lat);
    check("in_ready_low_while_busy", ready_high, 0);
    e = scoreboard.pop_front();
    check("result", result, e.val);
    check("rd_o", rd_o, e.rd);
    if (hold > 0) begin
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clock);
        if (!out_valid || result !== e.val || rd_o !== e.rd) stable = 1'b0;
      end
      check("backpressure_stable", stable, 1);
      out_ready = 1'b1;
    end
    @(negedge clock);
    check("out_valid_drained", out_valid, 0);
    check("in_ready_after_drain", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]  r_op;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [63:0] rexp;
    int          rlat;

    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    op        = '0;
    src1      = '0;
    src2      = '0;
    rd_i      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    vecs.push_back('{OP_MUL,    64'd7,   ONES - 64'd2, 5'd5,  64'hFFFF_FFFF_FFFF_FFEB, 66});
    vecs.push_back('{OP_MULHU,  ONES,    ONES,         5'd6,  64'hFFFF_FFFF_FFFF_FFFE, 66});
    vecs.push_back('{OP_MULH,   ONES,    ONES,         5'd7,  64'd0,                   66});
    vecs.push_back('{OP_MULHSU, ONES,    64'd2,        5'd8,  ONES,                    66});
    vecs.push_back('{OP_DIV,    -64'd20, 64'd3,        5'd9,  -64'd6,                  66});
    vecs.push_back('{OP_REM,    -64'd20, 64'd3,        5'd10, -64'd2,                  66});
    vecs.push_back('{OP_DIVU,   64'd100, 64'd7,        5'd11, 64'd14,                  66});
    vecs.push_back('{OP_REMU,   64'd100, 64'd7,        5'd12, 64'd2,                   66});
    vecs.push_back('{OP_DIV,    64'd5,   64'd0,        5'd13, ONES,                    1});
    vecs.push_back('{OP_REM,    64'd5,   64'd0,        5'd14, 64'd5,                   1});
    vecs.push_back('{OP_DIV,    MINV,    ONES,         5'd15, MINV,                    1});
    vecs.push_back('{OP_REM,    MINV,    ONES,         5'd16, 64'd0,                   1});
    vecs.push_back('{8'h00,     64'd9,   64'd3,        5'd17, 64'd0,                   1});
    vecs.push_back('{8'h03,     64'd9,   64'd3,        5'd18, 64'd0,                   1});
    vecs.push_back('{OP_MUL,    MINV,    ONES,         5'd19, MINV,                    66});
    vecs.push_back('{OP_MULH,   MINV,    MINV,         5'd20, 64'h4000_0000_0000_0000, 66});
    vecs.push_back('{OP_DIV,    64'd7,   -64'd2,       5'd21, -64'd3,                  66});
    vecs.push_back('{OP_REM,    64'd7,   -64'd2,       5'd22, 64'd1,                   66});
    vecs.push_back('{OP_DIVU,   ONES,    64'd1,        5'd23, ONES,                    66});
    vecs.push_back('{OP_REMU,   64'd5,   64'd0,        5'd24, 64'd5,                   1});

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_rd_o", rd_o, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 1'b1);
      checkOutput(vecs[i].lat, 0);
    end

    for (int i = 0; i < 8; i++) begin
      r_op = 8'h01 << $urandom_range(0, 7);
      ra   = {$urandom, $urandom};
      rb   = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(1, 1000));
      rexp = model(r_op, ra, rb);
      rlat = ((|r_op[7:4]) && rb == 64'd0) ||
             ((r_op == OP_DIV || r_op == OP_REM) && ra == MINV && rb == ONES) ? 1 : 66;
      applyStimulus(r_op, ra, rb, 5'(i + 1), rexp, 1'b1);
      checkOutput(rlat, 0);
    end

    // Consumer stalls for 10 cycles after the result appears.
    applyStimulus(OP_MULHU, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5'd27,
                  model(OP_MULHU, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321), 1'b1);
    checkOutput(66, 10);

    // Flush in cycle 30 of a divide, then a fresh multiply.
    applyStimulus(OP_DIV, 64'd1000, 64'd7, 5'd3, 64'd0, 1'b0);
    repeat (29) @(negedge clock);
    check("busy_before_flush", busy, 1);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    @(negedge clock);
    check("flush_busy", busy, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    applyStimulus(OP_MUL, 64'd123456789, -64'd1000, 5'd4,
                  model(OP_MUL, 64'd123456789, -64'd1000), 1'b1);
    checkOutput(66, 0);

    // Reset in the middle of a multiply.
    applyStimulus(OP_MUL, 64'd3, 64'd5, 5'd9, 64'd0, 1'b0);
    repeat (20) @(negedge clock);
    check("busy_mid_mul", busy, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_result", result, 0);
    check("midreset_rd_o", rd_o, 0);
    check("midreset_busy", busy, 0);

    // Flush and in_valid together: nothing is accepted.
    @(negedge clock);
    flush    = 1'b1;
    in_valid = 1'b1;
    op       = OP_MUL;
    src1     = 64'd2;
    src2     = 64'd2;
    rd_i     = 5'd30;
    #1;
    check("flush_blocks_in_ready", in_ready, 0);
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    check("flush_in_valid_busy", busy, 0);
    check("flush_in_valid_out_valid", out_valid, 0);

    check("scoreboard_empty", scoreboard.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle sequencer for the M-extension operations (mul, mulh, mulhsu, mulhu, div, divu, rem, remu) decoded in D.
- Sits beside the single-cycle ALU in E. E hands it one operation through a valid/ready handshake.
- Runs an iterative 64-step shift-add multiply or restoring divide on operand magnitudes, applies the sign fix-up, and holds the result until the consumer takes it.
- Handles only one operation at a time; supports pipeline flush.

Parameters:
- XLEN, 64, operand/result width.
- CNT_W, 7, width of the iteration counter; must hold XLEN.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- in_valid, in, 1, E presents an operation.
- in_ready, out, 1, sequencer can accept; equals (state==IDLE) & ~flush.
- op, in, 8, one-hot {remu,rem,divu,div,mulhu,mulhsu,mulh,mul}; bit0 = mul.
- src1, in, XLEN, rs1 value.
- src2, in, XLEN, rs2 value.
- rd_i, in, 5, destination register tag.
- flush, in, 1, kill any in-flight operation.
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer accepts result.
- result, out, XLEN, final result.
- rd_o, out, 5, tag of the result.
- busy, out, 1, state != IDLE; used for hazard stalling.

Behaviour:
- States: IDLE, MUL, DIV, FIX, DONE.
- Reset: state=IDLE; out_valid=0; result=0; rd_o=0; busy=0; counter=0. Reset wins over every other input.
- Accept: handshake (in_valid & in_ready) at edge of cycle 0 latches op, rd_i, the operand magnitudes and the sign flags.
  - mul/mulh/div/rem: both operands are signed.
  - mulhsu: src1 is signed, src2 is unsigned.
  - mulhu/divu/remu: both operands are unsigned.
- Next state after accept:
  - mul*: MUL.
  - div*/rem*: DIV.
  - Fast cases (below): DONE directly.
- MUL: 64 cycles (cycles 1..64). Each cycle: if the multiplier LSB is 1, add the multiplicand into the upper half of a 128-bit accumulator; then shift right one bit. Counter 0..63; move to FIX when the counter reaches 63.
- DIV: 64 cycles of restoring division on magnitudes. Each cycle: shift the partial remainder left, take in the next dividend bit, trial-subtract the divisor; the quotient bit is 1 if the result is non-negative. Move to FIX after 64 steps.
- FIX (cycle 65), one cycle:
  - Negate the 128-bit product if the product sign is negative.
  - Negate the quotient if the operand signs differ (signed ops).
  - Negate the remainder if the dividend is negative (signed ops).
  - Select the result: mul = low 64 bits; mulh/mulhsu/mulhu = high 64 bits; div/divu = quotient; rem/remu = remainder.
  - Go to DONE.
- DONE: out_valid=1 from cycle 66. result and rd_o are stable until (out_valid & out_ready). Then go to IDLE, out_valid=0 next cycle.
  - Total latency from accept to out_valid: 66 cycles for normal ops, 1 cycle for fast cases.
- Fast cases, resolved at accept, go straight to DONE (out_valid in cycle 1):
  - Divide by zero: div/divu result = all ones; rem/remu result = src1.
  - Signed overflow (src1 = 0x8000_0000_0000_0000, src2 = -1): div result = 0x8000_0000_0000_0000; rem result = 0.
  - op not exactly one-hot: result = 0.
- Flush: in any state, next state = IDLE, out_valid=0 next cycle, no result is delivered.
  - Flush and in_valid in the same cycle: flush wins; in_ready=0, so nothing is accepted.
  - Flush during DONE together with out_ready: the transfer counts (consumer saw valid & ready); state still goes to IDLE.
- No overlap: in_ready=0 in MUL, DIV, FIX and DONE. A new operation can be accepted in the first cycle after DONE drains.
- Operand values on src1/src2 are ignored after the accept cycle.

Test Plan:
- mul: src1=7, src2=-3 (0xFFFF_FFFF_FFFF_FFFD), out_ready=1 -> out_valid at cycle 66, result=0xFFFF_FFFF_FFFF_FFEB, rd_o echoes rd_i; in_ready=0 for cycles 1..66.
- mulhu: 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. mulh: -1×-1 -> 0. mulhsu: src1=-1, src2=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- div: -20 / 3 -> -6; rem: -20 / 3 -> -2; divu 100/7 -> 14; remu 100/7 -> 2; each with out_valid at cycle 66.
- Corner cases, each with out_valid at cycle 1:
  - div 5/0 -> 0xFFFF_FFFF_FFFF_FFFF.
  - rem 5/0 -> 5.
  - div 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
  - rem of the same operands -> 0.
- Back-pressure: out_ready=0 for 10 cycles after out_valid -> result and rd_o are stable and out_valid stays 1. Raise out_ready -> out_valid=0 and in_ready=1 next cycle.
- Flush and reset:
  - flush at cycle 30 of a div -> IDLE next cycle, no out_valid. A new mul accepted right after completes with the correct value.
  - reset asserted mid-MUL -> all outputs 0, busy=0 next cycle.
  - flush and in_valid in the same cycle -> not accepted.
